// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared state encoding and default sizes for the AES request arbiter
package aes_arb_pkg;
  localparam int DW_DEF = 128;
  localparam int TIMEOUT_DEF = 64;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
endpackage

// File: rtl/aes_rr_arb2.sv
// aes_rr_arb2: two-way round-robin grant; on a tie the side not granted last wins
module aes_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  always_comb grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/aes_arbiter.sv
// aes_arbiter: shares one AES core between two requesters, one block in flight at a time
module aes_arbiter
  import aes_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic          req1_valid,
  output logic          req0_ready,
  output logic          req1_ready,
  input  logic [DW-1:0] req0_key,
  input  logic [DW-1:0] req1_key,
  input  logic [DW-1:0] req0_text,
  input  logic [DW-1:0] req1_text,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  input  logic          rsp0_ready,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp0_data,
  output logic [DW-1:0] rsp1_data,
  output logic          core_valid_in,
  output logic [DW-1:0] core_cipher_key,
  output logic [DW-1:0] core_plain_text,
  input  logic          core_valid_out,
  input  logic [DW-1:0] core_cipher_text,
  output logic          busy,
  output logic          timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  state_t state, state_nx;
  logic last, gnt, sel_rdy, timed_out, idle;
  logic [1:0] grant;
  logic [TW-1:0] timer;
  logic [DW-1:0] key_q, text_q, data0_q, data1_q;
  aes_rr_arb2 u_arb (
    .req  ({req1_valid, req0_valid}),
    .last (last),
    .grant(grant)
  );
  always_comb begin
    idle = state == IDLE;
    sel_rdy = gnt ? rsp1_ready : rsp0_ready;
    timed_out = timer == TW'(TIMEOUT_CYCLES - 1);
    // ready is masked during reset so every output reads 0 while reset is held
    req0_ready = reset && idle && grant[0];
    req1_ready = reset && idle && grant[1];
    core_valid_in = state == ISSUE;
    busy = !idle;
    rsp0_valid = state == RESP && !gnt;
    rsp1_valid = state == RESP && gnt;
    rsp0_data = data0_q;
    rsp1_data = data1_q;
    core_cipher_key = key_q;
    core_plain_text = text_q;
    state_nx = state;
    case (state)
      IDLE:  state_nx = |grant ? ISSUE : IDLE;
      ISSUE: state_nx = WAIT;
      WAIT:  state_nx = core_valid_out ? RESP : (timed_out ? IDLE : WAIT);
      RESP:  state_nx = sel_rdy ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last <= 1'b1;
      gnt <= 1'b0;
      timer <= '0;
      key_q <= '0;
      text_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= (state == WAIT) ? timer + 1'b1 : '0;
      if (idle && |grant) begin
        key_q <= grant[1] ? req1_key : req0_key;
        text_q <= grant[1] ? req1_text : req0_text;
        gnt <= grant[1];
      end
      if (state == WAIT && core_valid_out && !gnt) data0_q <= core_cipher_text;
      if (state == WAIT && core_valid_out && gnt) data1_q <= core_cipher_text;
      if (state == WAIT && !core_valid_out && timed_out) timeout_err <= 1'b1;
      if (state == RESP && sel_rdy) last <= gnt;
    end
  end
endmodule

// File: tb/tb_aes_arbiter.sv
// tb_aes_arbiter: directed stimulus with a transaction-timeline model checked every cycle
module tb_aes_arbiter;
  localparam int DW = 128;
  localparam int TO = 64;
  localparam logic [DW-1:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [DW-1:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [DW-1:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [DW-1:0] K0 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [DW-1:0] P0 = 128'hdeadbeef_00000001_cafef00d_00000002;
  localparam logic [DW-1:0] K1 = 128'h99999999_88888888_77777777_66666666;
  localparam logic [DW-1:0] P1 = 128'h0badf00d_12345678_9abcdef0_fedcba98;
  logic clk = 0, reset = 0;
  logic req0_valid = 0, req1_valid = 0, rsp0_ready = 0, rsp1_ready = 0;
  logic [DW-1:0] req0_key = '0, req1_key = '0, req0_text = '0, req1_text = '0;
  logic core_valid_out = 0;
  logic [DW-1:0] core_cipher_text = '0;
  logic req0_ready, req1_ready, rsp0_valid, rsp1_valid, core_valid_in, busy, timeout_err;
  logic [DW-1:0] rsp0_data, rsp1_data, core_cipher_key, core_plain_text;
  int cyc = 0, checks = 0, errors = 0;
  aes_arbiter #(.TIMEOUT_CYCLES(TO), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_key(req0_key), .req1_key(req1_key),
    .req0_text(req0_text), .req1_text(req1_text),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data),
    .core_valid_in(core_valid_in), .core_cipher_key(core_cipher_key),
    .core_plain_text(core_plain_text), .core_valid_out(core_valid_out),
    .core_cipher_text(core_cipher_text), .busy(busy), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  function automatic logic [DW-1:0] aes_fn(input logic [DW-1:0] k, input logic [DW-1:0] t);
    if (k == FK && t == FP) return FC;
    return k ^ {t[63:0], t[127:64]} ^ 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
  endfunction
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask
  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask
  // core stand-in: answers core_lat cycles after the start strobe unless muted
  int core_lat = 10, due = -1, spur_at = -1;
  bit core_mute = 0, pend = 0;
  logic [DW-1:0] ck, cp;
  always @(negedge clk)
    if (reset && core_valid_in && !core_mute) begin
      pend = 1;
      due = cyc + core_lat;
      ck = core_cipher_key;
      cp = core_plain_text;
    end
  always @(posedge clk) begin
    bit hit;
    cyc++;
    #1;
    hit = pend && cyc == due;
    core_valid_out = hit || cyc == spur_at;
    core_cipher_text = hit ? aes_fn(ck, cp) : (cyc == spur_at ? 128'hbad : '0);
    if (hit) pend = 0;
  end
  // model: a transaction is granted at m_t, starts the core at m_t+1, waits from m_t+2
  bit m_in = 0, m_last = 1, m_err = 0, m_g = 0;
  int m_t = 0, m_resp = -1;
  logic [DW-1:0] m_key = '0, m_text = '0;
  logic [DW-1:0] m_data [2] = '{'0, '0};
  int dut_grants[$];
  always @(negedge clk) begin
    int win, k;
    logic [1:0] ev;
    bit busy_e, cvi_e;
    if (!reset) begin
      chk1("rst_req0_ready", req0_ready, 0);
      chk1("rst_req1_ready", req1_ready, 0);
      chk1("rst_rsp0_valid", rsp0_valid, 0);
      chk1("rst_rsp1_valid", rsp1_valid, 0);
      chk1("rst_core_valid_in", core_valid_in, 0);
      chk1("rst_busy", busy, 0);
      chk1("rst_timeout_err", timeout_err, 0);
      chkd("rst_rsp0_data", rsp0_data, '0);
      chkd("rst_rsp1_data", rsp1_data, '0);
      chkd("rst_core_key", core_cipher_key, '0);
      chkd("rst_core_text", core_plain_text, '0);
      m_in = 0; m_last = 1; m_err = 0; m_key = '0; m_text = '0;
      m_data[0] = '0; m_data[1] = '0;
    end else begin
      win = -1; ev = '0; busy_e = 0; cvi_e = 0; k = 0;
      if (!m_in) begin
        if (req0_valid && req1_valid) win = m_last ? 0 : 1;
        else if (req0_valid) win = 0;
        else if (req1_valid) win = 1;
      end else begin
        k = cyc - m_t;
        busy_e = 1;
        cvi_e = k == 1;
        if (m_resp >= 0 && cyc >= m_resp) ev[m_g] = 1;
      end
      chk1("req0_ready", req0_ready, win == 0);
      chk1("req1_ready", req1_ready, win == 1);
      chk1("busy", busy, busy_e);
      chk1("core_valid_in", core_valid_in, cvi_e);
      chk1("rsp0_valid", rsp0_valid, ev[0]);
      chk1("rsp1_valid", rsp1_valid, ev[1]);
      chkd("rsp0_data", rsp0_data, m_data[0]);
      chkd("rsp1_data", rsp1_data, m_data[1]);
      chkd("core_key", core_cipher_key, m_key);
      chkd("core_text", core_plain_text, m_text);
      chk1("timeout_err", timeout_err, m_err);
      if (req0_ready) dut_grants.push_back(0);
      if (req1_ready) dut_grants.push_back(1);
      if (win >= 0) begin
        m_in = 1; m_t = cyc; m_g = win == 1; m_resp = -1;
        m_key = m_g ? req1_key : req0_key;
        m_text = m_g ? req1_text : req0_text;
      end else if (m_in) begin
        if (ev[m_g] && (m_g ? rsp1_ready : rsp0_ready)) begin
          m_in = 0;
          m_last = m_g;
        end else if (k >= 2 && m_resp < 0) begin
          if (core_valid_out) begin
            m_resp = cyc + 1;
            m_data[m_g] = aes_fn(m_key, m_text);
          end else if (k - 2 == TO - 1) begin
            m_err = 1;
            m_in = 0;
          end
        end
      end
    end
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic at_neg(input int c);
    do @(negedge clk); while (cyc < c);
  endtask
  task automatic request(input int n, input logic [DW-1:0] k, input logic [DW-1:0] t, output int tg);
    bit ok = 0;
    tg = -1;
    if (n == 0) begin req0_key = k; req0_text = t; req0_valid = 1; end
    else begin req1_key = k; req1_text = t; req1_valid = 1; end
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if ((n == 0) ? req0_ready : req1_ready) begin ok = 1; tg = cyc; end
      step;
    end
    if (n == 0) req0_valid = 0; else req1_valid = 0;
    chk1("request_granted", ok, 1);
  endtask
  task automatic wait_idle;
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      step;
      ok = !busy && !rsp0_valid && !rsp1_valid;
    end
    chk1("wait_idle", ok, 1);
  endtask
  initial begin
    int t, n;
    logic [DW-1:0] d;
    int exp_g [4] = '{0, 1, 0, 1};
    repeat (3) step;
    reset = 1;
    step;
    // single FIPS-197 block, 10-cycle core
    rsp0_ready = 1;
    core_lat = 10;
    request(0, FK, FP, t);
    at_neg(t + 11);
    chk1("fips_early", rsp0_valid, 0);
    at_neg(t + 12);
    chk1("fips_valid", rsp0_valid, 1);
    chkd("fips_data", rsp0_data, FC);
    chk1("fips_rsp1", rsp1_valid, 0);
    wait_idle;
    reset = 0;
    step; step;
    reset = 1;
    step;
    // both requesters streaming: grants must alternate from requester 0
    rsp1_ready = 1;
    core_lat = 3;
    req0_key = K0; req0_text = P0; req1_key = K1; req1_text = P1;
    dut_grants.delete();
    req0_valid = 1; req1_valid = 1;
    for (int i = 0; i < 200 && dut_grants.size() < 4; i++) step;
    req0_valid = 0; req1_valid = 0;
    wait_idle;
    n = dut_grants.size();
    chk1("rr_count", n == 4, 1);
    for (int i = 0; i < 4; i++) chk1("rr_order", i < n && dut_grants[i] == exp_g[i], 1);
    chkd("rr_data0", rsp0_data, aes_fn(K0, P0));
    chkd("rr_data1", rsp1_data, aes_fn(K1, P1));
    // backpressure on rsp0 while requester 1 waits
    rsp0_ready = 0;
    core_lat = 2;
    request(0, K1, P0, t);
    req1_key = K0; req1_text = P1; req1_valid = 1;
    at_neg(t + 4);
    d = rsp0_data;
    chkd("bp_data", d, aes_fn(K1, P0));
    for (int i = 0; i < 20; i++) begin
      chk1("bp_valid", rsp0_valid, 1);
      chkd("bp_stable", rsp0_data, d);
      chk1("bp_req1_ready", req1_ready, 0);
      if (i < 19) @(negedge clk);
    end
    step;
    rsp0_ready = 1;
    begin
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        ok = req1_ready;
      end
      chk1("bp_req1_after", ok, 1);
    end
    step;
    req1_valid = 0;
    wait_idle;
    chkd("bp_rsp1_data", rsp1_data, aes_fn(K0, P1));
    // silent core: abort after TO cycles in WAIT, then recover
    core_mute = 1;
    request(0, P0, K0, t);
    at_neg(t + 2 + TO - 1);
    chk1("to_not_yet", timeout_err, 0);
    chk1("to_busy_before", busy, 1);
    at_neg(t + 2 + TO);
    chk1("to_set", timeout_err, 1);
    chk1("to_idle", busy, 0);
    chk1("to_no_rsp", rsp0_valid, 0);
    core_mute = 0;
    step;
    request(1, P1, K1, t);
    wait_idle;
    chk1("to_sticky", timeout_err, 1);
    chkd("to_recover_data", rsp1_data, aes_fn(P1, K1));
    // stray core strobe in IDLE
    spur_at = cyc + 1;
    step; step; step;
    chk1("spur_busy", busy, 0);
    chk1("spur_rsp0", rsp0_valid, 0);
    chk1("spur_rsp1", rsp1_valid, 0);
    // reset during WAIT, late core answer after release
    core_lat = 8;
    request(0, FK, FP, t);
    step; step;
    reset = 0;
    step; step;
    reset = 1;
    at_neg(t + 9);
    chk1("late_strobe_seen", core_valid_out, 1);
    at_neg(t + 10);
    chk1("late_no_rsp0", rsp0_valid, 0);
    chk1("late_busy", busy, 0);
    chk1("late_err_cleared", timeout_err, 0);
    chkd("late_data", rsp0_data, '0);
    step; step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_arbiter.md
AES_ARBITER -- requirements
Module: aes_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: maximum cycles spent in WAIT before abort.
REQ-002 Parameter DW, default 128: key, text and cipher width.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req0_valid / req1_valid  in  1  requester N offers a block.
REQ-006 req0_ready / req1_ready  out  1  arbiter accepts requester N's block this cycle.
REQ-007 req0_key / req1_key  in  DW  cipher key from requester N.
REQ-008 req0_text / req1_text  in  DW  plain text from requester N.
REQ-009 rsp0_valid / rsp1_valid  out  1  cipher result available for requester N.
REQ-010 rsp0_ready / rsp1_ready  in  1  requester N takes the result.
REQ-011 rsp0_data / rsp1_data  out  DW  cipher text for requester N.
REQ-012 core_valid_in  out  1  one-cycle start strobe to the AES core.
REQ-013 core_cipher_key  out  DW  key driven to the core.
REQ-014 core_plain_text  out  DW  plain text driven to the core.
REQ-015 core_valid_out  in  1  core result strobe.
REQ-016 core_cipher_text  in  DW  core result.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 timeout_err  out  1  sticky; set on WAIT timeout.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP; at most one block is outstanding at the core.
REQ-020 In IDLE with any reqN_valid, the arbiter SHALL grant one requester, assert only its reqN_ready combinationally that cycle, register its key and text plus a grant index, and move to ISSUE.
REQ-021 Arbitration SHALL be round-robin: with both valid, the requester not granted last wins; with one valid, it wins regardless of history.
REQ-022 reqN_ready SHALL be 0 in every state other than IDLE.
REQ-023 In ISSUE, core_valid_in SHALL be 1 for exactly one cycle with the registered key and text, and the FSM SHALL move to WAIT with the timer cleared.
REQ-024 core_cipher_key and core_plain_text SHALL hold the registered values from ISSUE until the next grant.
REQ-025 In WAIT, core_valid_out SHALL capture core_cipher_text into the response register and move to RESP.
REQ-026 core_valid_out outside WAIT SHALL be ignored.
REQ-027 In WAIT, the timer SHALL increment each cycle; if TIMEOUT_CYCLES cycles pass without core_valid_out, timeout_err SHALL set, no response SHALL be produced, and the FSM SHALL return to IDLE.
REQ-028 In RESP, only the granted rspN_valid SHALL be 1, with rspN_data stable, until rspN_ready; on that handshake the FSM SHALL return to IDLE and the last-grant pointer SHALL update.
REQ-029 The non-granted rsp valid SHALL remain 0; rspN_data SHALL hold its last captured value.
REQ-030 Latency SHALL be: request handshake at cycle T, core_valid_in at T+1; core_valid_out at T+1+L gives rspN_valid at T+2+L.
REQ-031 With rspN_ready already high on entry to RESP, the FSM SHALL leave RESP after one cycle; a new grant SHALL occur no earlier than the following cycle in IDLE.

Reset
REQ-032 While reset=0, the state SHALL be IDLE and the last-grant pointer 1, so requester 0 wins the first tie.
REQ-033 All outputs and registers (data, timer, timeout_err) SHALL be 0 during reset.
REQ-034 Reset asserted mid-operation SHALL abandon the block without a response; a late core_valid_out after release SHALL be ignored per REQ-026.

Structure
REQ-035 Package aes_arb_pkg SHALL hold the state enum, the DW default and the TIMEOUT_CYCLES default.
REQ-036 Round-robin grant logic SHALL be a sub-module, aes_rr_arb2 (2-way, pointer input, one-hot grant output).

Verification
REQ-038 Single request, FIPS-197 C.1: req0 key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff, core model L=10 -> rsp0_data 69c4e0d86a7b0430d8cdb78070b4c55a at T+12; rsp1_valid stays 0.
REQ-039 req0 and req1 valid together for 4 back-to-back blocks -> grants in order 0,1,0,1; each response arrives on its own port with the matching data.
REQ-040 rsp0_ready held 0 for 20 cycles -> rsp0_valid and data stable for those cycles; req1_ready stays 0 until the rsp0 handshake.
REQ-041 Core never asserts valid_out, TIMEOUT_CYCLES=64 -> timeout_err=1 at WAIT+64, FSM in IDLE, no rsp valid; next request completes normally with timeout_err still 1.
REQ-042 reset pulled low during WAIT, then core_valid_out pulses after release -> all outputs 0, no response, busy=0.
REQ-043 Spurious core_valid_out in IDLE -> no state change, no rsp valid.
